// File: rtl/demorgan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demorgan_pkg
// Description : Shared types and constants for the De Morgan truth-table
//               checker: sequencer states, vector count and response bit map.
// Revision    : 1.0 - initial release
// ============================================================================
package demorgan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int RESP_W      = 6;

    // Bit positions inside the response word {nA,nB,nAandnB,nAorB,nAornB,nAandB}
    localparam int BIT_NA      = 5;
    localparam int BIT_NB      = 4;
    localparam int BIT_NANDNB  = 3;
    localparam int BIT_NAORB   = 2;
    localparam int BIT_NAORNB  = 1;
    localparam int BIT_NANDB   = 0;

endpackage
`default_nettype wire

// File: rtl/demorgan_golden.sv
`default_nettype none
// ============================================================================
// Module      : demorgan_golden
// Description : Combinational golden De Morgan responses for one A/B vector.
// Revision    : 1.0 - initial release
// ============================================================================
module demorgan_golden
    import demorgan_pkg::*;
(
    input  logic              a,
    input  logic              b,
    output logic [RESP_W-1:0] golden
);

    always_comb begin
        golden             = '0;
        golden[BIT_NA]     = ~a;
        golden[BIT_NB]     = ~b;
        golden[BIT_NANDNB] = ~a & ~b;
        golden[BIT_NAORB]  = ~(a | b);
        golden[BIT_NAORNB] = ~a | ~b;
        golden[BIT_NANDB]  = ~(a & b);
    end

endmodule
`default_nettype wire

// File: rtl/demorgan_checker.sv
`default_nettype none
// ============================================================================
// Module      : demorgan_checker
// Description : Drives the four A/B vectors into a De Morgan block, samples
//               its six responses after SETTLE_CYCLES and counts mismatches.
//               Optional first-failure capture: DEMORGAN_CHECKER_FIRSTFAIL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module demorgan_checker
    import demorgan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              A,
    output logic              B,
    input  logic              nA,
    input  logic              nB,
    input  logic              nAandnB,
    input  logic              nAorB,
    input  logic              nAornB,
    input  logic              nAandB,
    output logic              busy,
    output logic              done,
    output logic              pass,
`ifdef DEMORGAN_CHECKER_FIRSTFAIL_EN
    output logic              fail_valid,
    output logic [1:0]        fail_vec,
    output logic [RESP_W-1:0] fail_bits,
`endif
    output logic [2:0]        err_count,
    output logic [1:0]        vec_idx
);

    localparam int               CNT_W      = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [1:0]       c_last_vec = 2'(NUM_VECTORS - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_a;
    logic              r_b;
    logic [1:0]        r_vec_idx;
    logic [2:0]        r_err_count;
    logic              r_busy;
    logic              r_done;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_accept;
    logic              w_mismatch;
    logic [RESP_W-1:0] w_resp;
    logic [RESP_W-1:0] w_golden;

    demorgan_golden u_golden (
        .a      (r_a),
        .b      (r_b),
        .golden (w_golden)
    );

    always_comb begin
        w_resp             = '0;
        w_resp[BIT_NA]     = nA;
        w_resp[BIT_NB]     = nB;
        w_resp[BIT_NANDNB] = nAandnB;
        w_resp[BIT_NAORB]  = nAorB;
        w_resp[BIT_NAORNB] = nAornB;
        w_resp[BIT_NANDB]  = nAandB;
    end

    assign w_accept   = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_mismatch = (r_state == SAMPLE) && (w_resp != w_golden);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_state_next = SETTLE;
            SETTLE:     if (r_cnt == c_cnt_one) w_state_next = SAMPLE;
            SAMPLE:     w_state_next = (r_vec_idx == c_last_vec) ? DONE : SETTLE;
            default:    w_state_next = IDLE;
        endcase
    end

    // busy/done are registered from the next state so no output besides pass is combinational
    always_comb begin
        w_busy_next = (w_state_next == SETTLE) || (w_state_next == SAMPLE);
        w_done_next = (w_state_next == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            r_done <= w_done_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_vec_idx   <= 2'd0;
            r_err_count <= 3'd0;
            r_cnt       <= '0;
        end else if (w_accept) begin
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_vec_idx   <= 2'd0;
            r_err_count <= 3'd0;
            r_cnt       <= c_cnt_load;
        end else if (r_state == SETTLE) begin
            r_cnt <= r_cnt - c_cnt_one;
        end else if (r_state == SAMPLE) begin
            if (w_mismatch) r_err_count <= r_err_count + 3'd1;
            if (r_vec_idx != c_last_vec) begin
                r_vec_idx    <= r_vec_idx + 2'd1;
                {r_a, r_b}   <= r_vec_idx + 2'd1;
                r_cnt        <= c_cnt_load;
            end
        end
    end

`ifdef DEMORGAN_CHECKER_FIRSTFAIL_EN
    logic              r_fail_valid;
    logic [1:0]        r_fail_vec;
    logic [RESP_W-1:0] r_fail_bits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 2'd0;
            r_fail_bits  <= '0;
        end else if (w_accept) begin
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 2'd0;
            r_fail_bits  <= '0;
        end else if (w_mismatch && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_vec   <= r_vec_idx;
            r_fail_bits  <= w_resp ^ w_golden;
        end
    end

    assign fail_valid = r_fail_valid;
    assign fail_vec   = r_fail_vec;
    assign fail_bits  = r_fail_bits;
`endif

    assign A         = r_a;
    assign B         = r_b;
    assign vec_idx   = r_vec_idx;
    assign err_count = r_err_count;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_done && (r_err_count == 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_demorgan_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_demorgan_checker
// Description : Self-checking bench: a fault-injectable, 2-cycle-latency
//               De Morgan block model driven by the checker, with randomized
//               faults and a truth-table reference for the expected verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demorgan_checker;

    localparam int SETTLE = 3;
    localparam int RUN_CYCLES = 4 * (SETTLE + 1);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       A, B, busy, done, pass;
    logic [2:0] err_count;
    logic [1:0] vec_idx;
    logic [5:0] resp;
`ifdef DEMORGAN_CHECKER_FIRSTFAIL_EN
    logic       fail_valid;
    logic [1:0] fail_vec;
    logic [5:0] fail_bits;
`endif

    int total = 0;
    int bad   = 0;

    // Fault configuration applied to the modelled gate block
    logic [5:0] sa0 = '0;
    logic [5:0] sa1 = '0;
    logic [5:0] flip [4];
    logic [1:0] ab_d1 = '0;
    logic [1:0] ab_d2 = '0;

    always #5 clk = ~clk;

    function automatic logic [5:0] gold(input logic [1:0] ab);
        int a, b;
        a = int'(ab[1]);
        b = int'(ab[0]);
        return {1'(1 - a), 1'(1 - b), 1'(a + b == 0), 1'(a + b == 0),
                1'(a + b < 2), 1'(a * b == 0)};
    endfunction

    function automatic logic [5:0] faulty(input logic [1:0] ab);
        return ((gold(ab) & ~sa0) | sa1) ^ flip[ab];
    endfunction

    always @(posedge clk) begin
        ab_d1 <= {A, B};
        ab_d2 <= ab_d1;
    end

    always_comb resp = ((gold(ab_d2) & ~sa0) | sa1) ^ flip[ab_d2];

    demorgan_checker #(.SETTLE_CYCLES(SETTLE)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
        .nA        (resp[5]),
        .nB        (resp[4]),
        .nAandnB   (resp[3]),
        .nAorB     (resp[2]),
        .nAornB    (resp[1]),
        .nAandB    (resp[0]),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
`ifdef DEMORGAN_CHECKER_FIRSTFAIL_EN
        .fail_valid(fail_valid),
        .fail_vec  (fail_vec),
        .fail_bits (fail_bits),
`endif
        .err_count (err_count),
        .vec_idx   (vec_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_once(input bit repulse);
        int         n;
        int         exp_err;
        int         first_vec;
        logic [5:0] first_bits;
        logic [1:0] seq [$];

        exp_err    = 0;
        first_vec  = -1;
        first_bits = '0;
        for (int v = 0; v < 4; v++) begin
            if (faulty(2'(v)) != gold(2'(v))) begin
                exp_err++;
                if (first_vec < 0) begin
                    first_vec  = v;
                    first_bits = faulty(2'(v)) ^ gold(2'(v));
                end
            end
        end

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("err_clr", 32'(err_count), 0);
        check("busy_on", 32'(busy), 1);
        seq.delete();
        seq.push_back({A, B});
        n = 0;
        while (!done && n < 100) begin
            if (repulse) start = (n == 1);
            @(posedge clk);
            #1;
            n++;
            if (busy) begin
                check("idx_ab", 32'(vec_idx), 32'({A, B}));
                if ({A, B} != seq[$]) seq.push_back({A, B});
            end
        end
        start = 1'b0;
        check("done_lat", n, RUN_CYCLES);
        check("err_count", 32'(err_count), exp_err);
        check("pass", 32'(pass), 32'(exp_err == 0));
        check("busy_off", 32'(busy), 0);
        check("hold_ab", 32'({A, B, vec_idx}), 32'hF);
        check("seq_len", seq.size(), 4);
        for (int i = 0; i < 4; i++)
            check("seq", (i < seq.size()) ? 32'(seq[i]) : 32'hFF, i);
`ifdef DEMORGAN_CHECKER_FIRSTFAIL_EN
        check("fail_valid", 32'(fail_valid), 32'(first_vec >= 0));
        check("fail_vec", 32'(fail_vec), (first_vec >= 0) ? first_vec : 0);
        check("fail_bits", 32'(fail_bits), 32'(first_bits));
`endif
    endtask

    task automatic set_faults(input logic [5:0] s0, input logic [5:0] s1);
        sa0 = s0;
        sa1 = s1 & ~s0;
        for (int v = 0; v < 4; v++) flip[v] = '0;
    endtask

    initial begin
        for (int v = 0; v < 4; v++) flip[v] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ab", 32'({A, B, vec_idx}), 0);
        check("rst_flags", 32'({busy, done, pass}), 0);
        check("rst_err", 32'(err_count), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_wait", 32'({busy, done}), 0);

        set_faults(6'b000000, 6'b000000);
        run_once(1'b0);
        set_faults(6'b000001, 6'b000000);  // nAandB stuck-at-0
        run_once(1'b0);
        set_faults(6'b000000, 6'b100000);  // nA stuck-at-1
        run_once(1'b0);
        set_faults(6'b000000, 6'b000000);
        run_once(1'b1);

        for (int r = 0; r < 20; r++) begin
            set_faults(6'($urandom_range(0, 63) & $urandom_range(0, 63) & $urandom_range(0, 63)),
                       6'($urandom_range(0, 63) & $urandom_range(0, 63) & $urandom_range(0, 63)));
            for (int v = 0; v < 4; v++)
                flip[v] = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            run_once(1'($urandom_range(0, 1)));
        end

        // Abort mid-run while vector 2 is being driven
        set_faults(6'b000000, 6'b000000);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 50 && vec_idx != 2'd2; n++) @(posedge clk);
        check("reach_v2", 32'(vec_idx), 2);
        #3;
        reset = 1'b1;
        #1;
        check("abort_ab", 32'({A, B, vec_idx}), 0);
        check("abort_flags", 32'({busy, done, pass}), 0);
        check("abort_err", 32'(err_count), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_idle", 32'({busy, done, A, B}), 0);
        run_once(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demorgan_checker.md
# demorgan_checker

Self-checking hardware sequencer for the De Morgan gate block. It drives all four A/B input vectors in order, waits a programmable settle time, and samples the block's six outputs. It compares them against golden De Morgan values and reports a mismatch count and a pass/fail verdict. It sits at the driving end of the demorgan interface, so a synthesised design can run the same truth-table check a simulation bench performs.

## Interface
- SETTLE_CYCLES, 1, cycles A/B are held before the DUT outputs are sampled; must be ≥1
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a check run; honoured only in IDLE or DONE
- A  output  1  registered stimulus to DUT input A
- B  output  1  registered stimulus to DUT input B
- nA, nB, nAandnB, nAorB, nAornB, nAandB  input  1 each  DUT responses
- busy  output  1  high in SETTLE/SAMPLE
- done  output  1  high while in DONE (level)
- pass  output  1  done && err_count==0
- err_count  output  3  number of mismatching vectors this run (0–4)
- vec_idx  output  2  index of the vector currently driven ({A,B})

## Operation
- Reset: state IDLE; A=B=0, vec_idx=0, err_count=0, busy=done=pass=0; settle counter 0.
- Response word R = {nA,nB,nAandnB,nAorB,nAornB,nAandB}, with bit5 = nA and bit0 = nAandB.
- Golden G(A,B) = {~A, ~B, ~A&~B, ~(A|B), ~A|~B, ~(A&B)}.
- A vector mismatches if R != G, i.e. any bit differs.
- States:
  - IDLE: waits for start. start=1 → SETTLE, vec_idx=0, A=B=0, err_count=0, settle counter=SETTLE_CYCLES.
  - SETTLE: decrement counter each cycle; counter==1 → SAMPLE.
  - SAMPLE: compare R against G(A,B); on mismatch err_count+=1.
    - If vec_idx==3 → DONE.
    - Else vec_idx+=1, {A,B}=vec_idx+1, counter reloads, → SETTLE.
  - DONE: done=1, pass valid. A, B, vec_idx hold at 3. start=1 → same entry as from IDLE; err_count clears.
- Vector order: 00, 01, 10, 11.
- start while busy is ignored.
- err_count saturates naturally at 4 and cannot wrap.
- Reset asserted mid-run aborts the run; all outputs return to reset values in the same instant.

## Timing
- A/B change on the clock edge that enters SETTLE. The DUT therefore has exactly SETTLE_CYCLES full cycles before the SAMPLE-cycle compare.
- Each vector occupies SETTLE_CYCLES+1 cycles.
- start accepted at edge N → done first high after edge N+4·(SETTLE_CYCLES+1).
- err_count updates on the edge leaving SAMPLE. It is final when done rises.
- Combinational paths: only pass, decoded from state and err_count. No input-to-output combinational path.

## Configuration
- DEMORGAN_CHECKER_FIRSTFAIL_EN defined: adds three outputs.
  - fail_valid (1 bit), fail_vec (2 bits), fail_bits (6 bits, = R XOR G).
  - They capture the first mismatching vector of a run.
  - fail_valid stays high until reset or the next accepted start; both clear it to 0 along with fail_vec and fail_bits.
  - Later mismatches do not overwrite the capture.
- Not defined: these ports and registers are absent. All other behaviour is identical.

## Structure
- Package demorgan_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}
  - NUM_VECTORS=4
  - RESP_W=6
  - response bit-position constants
- Sub-module demorgan_golden: combinational; A,B in → 6-bit G out. Reusable by benches.
- Settle counter width = $clog2(SETTLE_CYCLES+1).

## Test plan
- Correct DUT, SETTLE_CYCLES=1, pulse start → done rises 8 cycles later; err_count=0, pass=1; A/B sequence observed 00,01,10,11.
- nAandB stuck-at-0 → vectors 00, 01, 10 fail and 11 passes; err_count=3, pass=0. With FIRSTFAIL_EN: fail_vec=0, fail_bits=6'b000001.
- nA stuck-at-1 → vectors 10 and 11 fail; err_count=2. With FIRSTFAIL_EN: fail_vec=2, fail_bits=6'b100000.
- SETTLE_CYCLES=3 with a DUT whose outputs are delayed 2 cycles → err_count=0, done 16 cycles after start. Same DUT at SETTLE_CYCLES=1 → err_count>0.
- start re-pulsed during SETTLE → ignored, run completes unchanged. start in DONE → err_count clears and a new run begins.
- reset asserted during vector 2 → A=B=0, vec_idx=0, busy=done=0 immediately. After release, IDLE until start.
